// File: rtl/motor_mix_scheduler.sv
// Arm/disarm FSM plus one shared signed adder/clamp, time-multiplexed over motors M0..M3.
// Define MOTOR_MIX_SLEW_LIMIT_EN to limit each committed duty change to +/-MAX_STEP.
module motor_mix_scheduler #(
    parameter logic [7:0]  BASE_DUTY   = 8'd50,
    parameter logic [7:0]  MAX_DUTY    = 8'd100,
    parameter logic [7:0]  ARM_THR_MAX = 8'd5,
    parameter int unsigned ARM_TICKS   = 8
`ifdef MOTOR_MIX_SLEW_LIMIT_EN
    ,
    parameter logic [7:0]  MAX_STEP    = 8'd4
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       update_tick,
    input  logic       arm_req,
    input  logic       failsafe,
    input  logic [7:0] throttle_offset,
    input  logic [7:0] pitch_offset,
    input  logic [7:0] roll_offset,
    input  logic [7:0] yaw_offset,
    output logic [7:0] motor0_duty,
    output logic [7:0] motor1_duty,
    output logic [7:0] motor2_duty,
    output logic [7:0] motor3_duty,
    output logic       duty_valid,
    output logic       armed,
    output logic       overrun
);

    typedef enum logic [1:0] {ST_DISARMED, ST_ARMING, ST_RUN} state_e;

    localparam logic [7:0] ARM_TICKS_W = 8'(ARM_TICKS);

    state_e           state_q, state_d;
    logic [7:0]       arm_cnt_q, arm_cnt_d;
    logic             busy_q, busy_d;
    logic [1:0]       step_q, step_d;
    logic [3:0][7:0]  duty_q, duty_d;
    logic             duty_valid_q, duty_valid_d;
    logic             armed_q, armed_d;
    logic             overrun_q, overrun_d;

    logic [7:0]       cap_t_q, cap_p_q, cap_r_q, cap_y_q;
    logic [3:0][7:0]  shadow_q;
    logic             cap_en, shadow_we;

    logic signed [10:0] p_ext, r_ext, y_ext, base_t, mix_sum;
    logic [7:0]         mix_clamped;
    logic [3:0][7:0]    commit;
    logic               disarm, thr_ok;

`ifdef MOTOR_MIX_SLEW_LIMIT_EN
    function automatic logic [7:0] slew(input logic [7:0] prev, input logic [7:0] target);
        if (target > prev)
            return (target - prev > MAX_STEP) ? prev + MAX_STEP : target;
        return (prev - target > MAX_STEP) ? prev - MAX_STEP : target;
    endfunction
`endif

    // Sign pattern per motor: P is negative on M2/M3, R on M1/M2, Y on M0/M2.
    always_comb begin
        p_ext  = {{3{cap_p_q[7]}}, cap_p_q};
        r_ext  = {{3{cap_r_q[7]}}, cap_r_q};
        y_ext  = {{3{cap_y_q[7]}}, cap_y_q};
        base_t = {3'b000, BASE_DUTY} + {3'b000, cap_t_q};
        mix_sum = base_t
                + (step_q[1]             ? -p_ext : p_ext)
                + ((step_q[1] ^ step_q[0]) ? -r_ext : r_ext)
                + (!step_q[0]            ? -y_ext : y_ext);
        if (mix_sum < 0)
            mix_clamped = 8'd0;
        else if (mix_sum > $signed({3'b000, MAX_DUTY}))
            mix_clamped = MAX_DUTY;
        else
            mix_clamped = mix_sum[7:0];
        commit = {mix_clamped, shadow_q[2], shadow_q[1], shadow_q[0]};
    end

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        state_d      = state_q;
        arm_cnt_d    = arm_cnt_q;
        busy_d       = busy_q;
        step_d       = step_q;
        duty_d       = duty_q;
        duty_valid_d = 1'b0;
        armed_d      = armed_q;
        overrun_d    = overrun_q;
        cap_en       = 1'b0;
        shadow_we    = 1'b0;
        disarm       = !arm_req || failsafe;
        thr_ok       = throttle_offset <= ARM_THR_MAX;

        if (state_q != ST_DISARMED && disarm) begin
            state_d      = ST_DISARMED;
            arm_cnt_d    = 8'd0;
            busy_d       = 1'b0;
            step_d       = 2'd0;
            duty_d       = '0;
            duty_valid_d = 1'b1;
            armed_d      = 1'b0;
        end else begin
            case (state_q)
                ST_DISARMED: begin
                    // The tick that enters ARMING counts as the first qualifying tick.
                    if (update_tick && !disarm && thr_ok) begin
                        state_d      = ST_ARMING;
                        arm_cnt_d    = 8'd1;
                        duty_d       = {4{BASE_DUTY}};
                        duty_valid_d = 1'b1;
                    end
                end
                ST_ARMING: begin
                    if (update_tick) begin
                        if (!thr_ok) begin
                            arm_cnt_d = 8'd0;
                        end else if (arm_cnt_q + 8'd1 >= ARM_TICKS_W) begin
                            state_d   = ST_RUN;
                            armed_d   = 1'b1;
                            arm_cnt_d = 8'd0;
                        end else begin
                            arm_cnt_d = arm_cnt_q + 8'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (busy_q) begin
                        shadow_we = 1'b1;
                        step_d    = step_q + 2'd1;
                        if (update_tick) overrun_d = 1'b1;
                        if (step_q == 2'd3) begin
                            busy_d       = 1'b0;
                            duty_valid_d = 1'b1;
`ifdef MOTOR_MIX_SLEW_LIMIT_EN
                            for (int k = 0; k < 4; k++) duty_d[k] = slew(duty_q[k], commit[k]);
`else
                            duty_d = commit;
`endif
                        end
                    end else if (update_tick) begin
                        cap_en = 1'b1;
                        busy_d = 1'b1;
                        step_d = 2'd0;
                    end
                end
                default: state_d = ST_DISARMED;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_DISARMED;
            arm_cnt_q    <= 8'd0;
            busy_q       <= 1'b0;
            step_q       <= 2'd0;
            duty_q       <= '0;
            duty_valid_q <= 1'b0;
            armed_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            arm_cnt_q    <= arm_cnt_d;
            busy_q       <= busy_d;
            step_q       <= step_d;
            duty_q       <= duty_d;
            duty_valid_q <= duty_valid_d;
            armed_q      <= armed_d;
            overrun_q    <= overrun_d;
        end
    end

    // NOTE: capture/shadow registers are not reset; they are only read while busy_q qualifies them.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            cap_t_q <= throttle_offset;
            cap_p_q <= pitch_offset;
            cap_r_q <= roll_offset;
            cap_y_q <= yaw_offset;
        end
        if (shadow_we) shadow_q[step_q] <= mix_clamped;
    end

    assign motor0_duty = duty_q[0];
    assign motor1_duty = duty_q[1];
    assign motor2_duty = duty_q[2];
    assign motor3_duty = duty_q[3];
    assign duty_valid  = duty_valid_q;
    assign armed       = armed_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_motor_mix_scheduler.sv
// Scoreboard bench for motor_mix_scheduler: stimulus pushes expected commits, a monitor pops them.
// The slew model is enabled when MOTOR_MIX_SLEW_LIMIT_EN is defined.
module tb_motor_mix_scheduler;

    localparam int M_DISARMED = 0;
    localparam int M_ARMING   = 1;
    localparam int M_RUN      = 2;

    typedef struct {
        int              cyc;
        logic [3:0][7:0] d;
        logic            armed;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       update_tick, arm_req, failsafe;
    logic [7:0] throttle_offset, pitch_offset, roll_offset, yaw_offset;
    logic [7:0] motor0_duty, motor1_duty, motor2_duty, motor3_duty;
    logic       duty_valid, armed, overrun;
    logic [3:0][7:0] dut_d;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb[$];
    exp_t mon_x;

    int   mode      = M_DISARMED;
    int   arm_cnt   = 0;
    int   last_busy = 0;
    int   last_d[4] = '{0, 0, 0, 0};
    logic exp_overrun = 1'b0;

    motor_mix_scheduler dut (
        .clk(clk), .rst_n(rst_n), .update_tick(update_tick), .arm_req(arm_req),
        .failsafe(failsafe), .throttle_offset(throttle_offset), .pitch_offset(pitch_offset),
        .roll_offset(roll_offset), .yaw_offset(yaw_offset),
        .motor0_duty(motor0_duty), .motor1_duty(motor1_duty),
        .motor2_duty(motor2_duty), .motor3_duty(motor3_duty),
        .duty_valid(duty_valid), .armed(armed), .overrun(overrun)
    );

    assign dut_d = {motor3_duty, motor2_duty, motor1_duty, motor0_duty};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference mix: the four motor equations evaluated with plain integers, then clamped.
    function automatic int mix_target(input int k, input int t, input int p, input int r, input int y);
        int m;
        case (k)
            0:       m = 50 + t + p + r - y;
            1:       m = 50 + t + p - r + y;
            2:       m = 50 + t - p - r - y;
            default: m = 50 + t - p + r + y;
        endcase
        if (m < 0)   m = 0;
        if (m > 100) m = 100;
        return m;
    endfunction

    // Monitor: every duty_valid must match the oldest expectation, on its cycle.
    always @(posedge clk) begin
        #1;
        if (rst_n === 1'b1) begin
            if (duty_valid === 1'b1) begin
                check("commit_expected", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_x = sb.pop_front();
                    check("commit_cycle", cyc, mon_x.cyc);
                    for (int k = 0; k < 4; k++)
                        check($sformatf("m%0d_duty", k), dut_d[k], mon_x.d[k]);
                    check("armed_at_commit", armed, mon_x.armed);
                end
            end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                check("commit_present", duty_valid, 1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic drive_tick();
        update_tick = 1'b1;
        @(negedge clk);
        update_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic issue_tick();
        int   e;
        int   tgt;
        exp_t x;
        e = cyc + 1;
        if (mode == M_RUN) begin
            if (e <= last_busy) begin
                exp_overrun = 1'b1;
            end else begin
                x.cyc   = e + 4;
                x.armed = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    tgt = mix_target(k, int'(throttle_offset), int'($signed(pitch_offset)),
                                     int'($signed(roll_offset)), int'($signed(yaw_offset)));
`ifdef MOTOR_MIX_SLEW_LIMIT_EN
                    if (tgt > last_d[k] + 4) tgt = last_d[k] + 4;
                    else if (tgt < last_d[k] - 4) tgt = last_d[k] - 4;
`endif
                    x.d[k]    = 8'(tgt);
                    last_d[k] = tgt;
                end
                sb.push_back(x);
                last_busy = e + 4;
            end
        end else if (mode == M_DISARMED) begin
            if (arm_req && !failsafe && throttle_offset <= 8'd5) begin
                mode    = M_ARMING;
                arm_cnt = 1;
                x.cyc   = e;
                x.armed = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    x.d[k]    = 8'd50;
                    last_d[k] = 50;
                end
                sb.push_back(x);
            end
        end else begin
            if (throttle_offset > 8'd5) arm_cnt = 0;
            else arm_cnt++;
            if (arm_cnt >= 8) mode = M_RUN;
        end
        drive_tick();
        check("armed_after_tick", armed, 32'(mode == M_RUN));
    endtask

    task automatic issue_disarm(input bit use_failsafe);
        int   e;
        exp_t x;
        e = cyc + 1;
        if (use_failsafe) failsafe = 1'b1;
        else arm_req = 1'b0;
        if (mode != M_DISARMED) begin
            while (sb.size() > 0 && sb[$].cyc >= e) void'(sb.pop_back());
            x.cyc   = e;
            x.armed = 1'b0;
            x.d     = '0;
            sb.push_back(x);
        end
        mode = M_DISARMED;
        arm_cnt = 0;
        last_busy = 0;
        for (int k = 0; k < 4; k++) last_d[k] = 0;
        @(negedge clk);
        failsafe = 1'b0;
        arm_req  = 1'b1;
        check("armed_after_disarm", armed, 0);
        check("m0_after_disarm", motor0_duty, 0);
    endtask

    task automatic set_mix(input int t, input int p, input int r, input int y);
        throttle_offset = 8'(t);
        pitch_offset    = 8'(p);
        roll_offset     = 8'(r);
        yaw_offset      = 8'(y);
    endtask

    task automatic random_frames(input int n);
        for (int i = 0; i < n; i++) begin
            set_mix(int'($urandom_range(0, 100)), int'($urandom), int'($urandom), int'($urandom));
            issue_tick();
            for (int g = 0; g < int'($urandom_range(5, 9)); g++) begin
                set_mix(int'($urandom_range(0, 255)), int'($urandom), int'($urandom), int'($urandom));
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        update_tick = 1'b0;
        arm_req = 1'b0;
        failsafe = 1'b0;
        set_mix(0, 0, 0, 0);
        idle(3);
        check("reset_m0", motor0_duty, 0);
        check("reset_m3", motor3_duty, 0);
        check("reset_valid", duty_valid, 0);
        check("reset_armed", armed, 0);
        check("reset_overrun", overrun, 0);
        rst_n = 1'b1;
        idle(2);

        // Arming refused while throttle is above the arming threshold.
        arm_req = 1'b1;
        set_mix(30, 0, 0, 0);
        issue_tick();
        idle(3);
        check("reject_m0", motor0_duty, 0);

        // Arm with throttle at the threshold: eight qualifying ticks reach RUN.
        set_mix(5, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            issue_tick();
            idle(2);
        end
        check("armed_m1_base", motor1_duty, 50);
        check("armed_m2_base", motor2_duty, 50);

        // Directed mix and both clamp directions.
        set_mix(20, 10, -5, 3);
        issue_tick();
        idle(8);
        set_mix(100, 60, 0, 0);
        issue_tick();
        idle(8);
        set_mix(0, -128, -128, 0);
        issue_tick();
        idle(8);

        // Second tick two cycles into a frame is ignored and flagged.
        set_mix(40, 7, 0, -9);
        issue_tick();
        @(negedge clk);
        set_mix(90, 90, 90, 90);
        issue_tick();
        idle(8);
        check("overrun_sticky", overrun, 32'(exp_overrun));

        random_frames(40);

        // Failsafe during the fourth cycle of a frame aborts it.
        set_mix(60, 20, 20, 20);
        issue_tick();
        idle(2);
        issue_disarm(1'b1);
        idle(8);

        // Re-arm, with an over-threshold tick clearing the count part way.
        set_mix(5, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            issue_tick();
            idle(1);
        end
        set_mix(20, 0, 0, 0);
        issue_tick();
        idle(1);
        set_mix(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            issue_tick();
            idle(1);
        end
        random_frames(15);

        // Disarm by dropping arm_req while idle in RUN.
        issue_disarm(1'b0);
        idle(4);

        // Re-arm and reset in the middle of a frame: no commit, sticky flag cleared.
        for (int i = 0; i < 8; i++) begin
            issue_tick();
            idle(1);
        end
        set_mix(50, 10, 10, 10);
        issue_tick();
        idle(1);
        rst_n = 1'b0;
        while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
        mode = M_DISARMED;
        arm_cnt = 0;
        last_busy = 0;
        for (int k = 0; k < 4; k++) last_d[k] = 0;
        idle(2);
        check("midreset_m0", motor0_duty, 0);
        check("midreset_armed", armed, 0);
        check("midreset_overrun", overrun, 0);
        rst_n = 1'b1;
        idle(10);

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
